// File: rtl/tlk2711_axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tlk2711_axil_pkg
//  Description : Shared response codes and FSM encodings for the TLK2711
//                AXI4-Lite register bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package tlk2711_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_EXEC = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ISSUE = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;
  localparam logic [1:0] R_RESP  = 2'd3;

endpackage : tlk2711_axil_pkg
`default_nettype wire

// File: rtl/axil_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : axil_reg_bridge
//  Description : AXI4-Lite (64-bit) slave driving the single-cycle strobe
//                register bus of the TLK2711 register manager.
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_reg_bridge
  import tlk2711_axil_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [63:0]               s_axil_wdata,
  input  logic [7:0]                s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [63:0]               s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic                      o_reg_wen,
  output logic [15:0]               o_reg_waddr,
  output logic [63:0]               o_reg_wdata,
  output logic                      o_reg_ren,
  output logic [15:0]               o_reg_raddr,
  input  logic [63:0]               i_reg_rdata
);

  localparam logic [3:0] c_RD_LAT = 4'(RD_LATENCY);

  // Readies stay low until the first clock edge after reset is released.
  logic        r_active;

  logic [1:0]  r_wstate;
  logic [1:0]  w_wstate_nxt;
  logic        r_aw_held;
  logic        r_w_held;
  logic [15:0] r_waddr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_wlegal;

  logic [1:0]  r_rstate;
  logic [1:0]  w_rstate_nxt;
  logic [15:0] r_raddr;
  logic [3:0]  r_rcnt;
  logic [63:0] r_rdata;
  logic        w_rlegal;

  if (AXI_ADDR_WIDTH > 16) begin : g_addr_upper
    logic w_unused_addr;
    assign w_unused_addr = ^{s_axil_awaddr[AXI_ADDR_WIDTH-1:16],
                             s_axil_araddr[AXI_ADDR_WIDTH-1:16]};
  end

  assign s_axil_awready = r_active && (r_wstate == W_IDLE) && !r_aw_held;
  assign s_axil_wready  = r_active && (r_wstate == W_IDLE) && !r_w_held;
  assign w_aw_hs        = s_axil_awvalid && s_axil_awready;
  assign w_w_hs         = s_axil_wvalid && s_axil_wready;
  assign w_wlegal       = (r_waddr[2:0] == 3'd0) && (r_wstrb == 8'hFF);

  assign o_reg_wen      = (r_wstate == W_EXEC) && w_wlegal;
  assign o_reg_waddr    = r_waddr;
  assign o_reg_wdata    = r_wdata;
  assign s_axil_bvalid  = (r_wstate == W_RESP);
  assign s_axil_bresp   = (s_axil_bvalid && !w_wlegal) ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) w_wstate_nxt = W_EXEC;
      W_EXEC: w_wstate_nxt = W_RESP;
      W_RESP: if (s_axil_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active  <= 1'b0;
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_active <= 1'b1;
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_waddr   <= s_axil_awaddr[15:0];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axil_wdata;
        r_wstrb  <= s_axil_wstrb;
      end
      if ((r_wstate == W_RESP) && s_axil_bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  assign s_axil_arready = r_active && (r_rstate == R_IDLE);
  assign w_rlegal       = (r_raddr[2:0] == 3'd0);
  assign o_reg_ren      = (r_rstate == R_ISSUE) && w_rlegal;
  assign o_reg_raddr    = r_raddr;
  assign s_axil_rvalid  = (r_rstate == R_RESP);
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = (s_axil_rvalid && !w_rlegal) ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (s_axil_arvalid && s_axil_arready) w_rstate_nxt = R_ISSUE;
      R_ISSUE: w_rstate_nxt = R_WAIT;
      R_WAIT:  if (r_rcnt == c_RD_LAT) w_rstate_nxt = R_RESP;
      R_RESP:  if (s_axil_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // r_rcnt holds the number of clocks elapsed since the ren cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_raddr  <= '0;
      r_rcnt   <= '0;
      r_rdata  <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (s_axil_arvalid && s_axil_arready) r_raddr <= s_axil_araddr[15:0];
      if (r_rstate == R_ISSUE) r_rcnt <= 4'd1;
      if (r_rstate == R_WAIT) begin
        r_rcnt <= r_rcnt + 4'd1;
        if (r_rcnt == c_RD_LAT) r_rdata <= w_rlegal ? i_reg_rdata : 64'd0;
      end
    end
  end

endmodule : axil_reg_bridge
`default_nettype wire

// File: tb/tb_axil_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_reg_bridge
//  Description : Self-checking bench for axil_reg_bridge with a register
//                manager model and a word-level expected register map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_reg_bridge;
  import tlk2711_axil_pkg::*;

  localparam int AW  = 32;
  localparam int RDL = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0, awready;
  logic [63:0]   wdata = '0;
  logic [7:0]    wstrb = '0;
  logic          wvalid = 1'b0, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0, arready;
  logic [63:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid, rready = 1'b0;
  logic          reg_wen, reg_ren;
  logic [15:0]   reg_waddr, reg_raddr;
  logic [63:0]   reg_wdata;
  logic [63:0]   reg_rdata = '0;

  int n_assert = 0;
  int n_fail   = 0;

  int          cyc = 0, wen_cnt = 0, ren_cnt = 0, wen_cyc = -1, ren_cyc = -1;
  logic [15:0] wen_addr = '0, ren_addr = '0;
  logic [63:0] wen_data = '0;

  logic [63:0] pmem [0:8191];
  bit          pw   [0:8191];
  logic [63:0] exp_mem [int];

  always #5 clk = ~clk;

  axil_reg_bridge #(.AXI_ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .o_reg_wen(reg_wen), .o_reg_waddr(reg_waddr), .o_reg_wdata(reg_wdata),
    .o_reg_ren(reg_ren), .o_reg_raddr(reg_raddr), .i_reg_rdata(reg_rdata)
  );

  function automatic logic [63:0] init_val(input int idx);
    return {32'hC0DE_0000 | 32'(idx), ~32'(idx)};
  endfunction

  function automatic logic [63:0] exp_read(input logic [15:0] a);
    int idx;
    idx = int'(a[15:3]);
    return exp_mem.exists(idx) ? exp_mem[idx] : init_val(idx);
  endfunction

  // Register manager: data appears the clock after ren; random filler otherwise.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    reg_rdata <= {$urandom, $urandom};
    if (reg_wen) begin
      wen_cnt  <= wen_cnt + 1;
      wen_cyc  <= cyc;
      wen_addr <= reg_waddr;
      wen_data <= reg_wdata;
      pmem[reg_waddr[15:3]] <= reg_wdata;
      pw[reg_waddr[15:3]]   <= 1'b1;
    end
    if (reg_ren) begin
      ren_cnt   <= ren_cnt + 1;
      ren_cyc   <= cyc;
      ren_addr  <= reg_raddr;
      reg_rdata <= pw[reg_raddr[15:3]] ? pmem[reg_raddr[15:3]] : init_val(int'(reg_raddr[15:3]));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
             reg_wen, reg_waddr, reg_wdata, reg_ren, reg_raddr};
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           input int awd, input int wd, input int bd, input string tag);
    int   k, n, t_hs, t_b, wen0;
    bit   aw_done, w_done, aw_p, w_p;
    logic legal;
    logic [1:0] exp_resp;
    legal    = (a[2:0] == 3'd0) && (s == 8'hFF);
    exp_resp = legal ? RESP_OKAY : RESP_SLVERR;
    wen0 = wen_cnt;
    k = 0; t_hs = 0; aw_done = 0; w_done = 0; aw_p = 0; w_p = 0;
    forever begin
      @(negedge clk);
      if (aw_p) aw_done = 1;
      if (w_p) w_done = 1;
      if (aw_done && w_done) break;
      if (w_done) chk({tag, "-wready_low"}, 64'(wready), 64'd0);
      if (aw_done) chk({tag, "-awready_low"}, 64'(awready), 64'd0);
      if (k > 60) begin
        chk({tag, "-handshake_timeout"}, 64'd1, 64'd0);
        awvalid = 0; wvalid = 0;
        return;
      end
      awvalid = !aw_done && (k >= awd); awaddr = a;
      wvalid  = !w_done && (k >= wd);   wdata = d; wstrb = s;
      #1;
      aw_p = awvalid && awready;
      w_p  = wvalid && wready;
      if (aw_p || w_p) t_hs = cyc;
      k++;
    end
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    t_b = cyc;
    chk({tag, "-bvalid_cycle"}, 64'(t_b), 64'(t_hs + 2));
    chk({tag, "-bresp"}, 64'(bresp), 64'(exp_resp));
    if (legal) begin
      chk({tag, "-wen_count"}, 64'(wen_cnt), 64'(wen0 + 1));
      chk({tag, "-wen_cycle"}, 64'(wen_cyc), 64'(t_hs + 1));
      chk({tag, "-wen_addr"}, 64'(wen_addr), 64'(a[15:0]));
      chk({tag, "-wen_data"}, wen_data, d);
      exp_mem[int'(a[15:3])] = d;
    end else begin
      chk({tag, "-no_wen"}, 64'(wen_cnt), 64'(wen0));
    end
    for (int i = 0; i < bd; i++) begin
      @(negedge clk);
      chk({tag, "-bvalid_held"}, 64'(bvalid), 64'd1);
      chk({tag, "-bresp_held"}, 64'(bresp), 64'(exp_resp));
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk({tag, "-bvalid_drop"}, 64'(bvalid), 64'd0);
    chk({tag, "-readies_back"}, 64'({awready, wready}), 64'd3);
    chk({tag, "-single_wen"}, 64'(wen_cnt), 64'(wen0 + (legal ? 1 : 0)));
  endtask

  task automatic axi_read(input logic [31:0] a, input int ad, input int rd, input string tag);
    int   n, t_hs, ren0;
    logic aligned;
    logic [63:0] exp_d;
    logic [1:0]  exp_resp;
    aligned  = (a[2:0] == 3'd0);
    exp_d    = aligned ? exp_read(a[15:0]) : 64'd0;
    exp_resp = aligned ? RESP_OKAY : RESP_SLVERR;
    ren0 = ren_cnt;
    repeat (ad) @(negedge clk);
    @(negedge clk);
    arvalid = 1; araddr = a;
    #1;
    n = 0;
    while (!arready && n < 40) begin @(negedge clk); #1; n++; end
    chk({tag, "-arready_seen"}, 64'(arready), 64'd1);
    t_hs = cyc;
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 40) begin @(negedge clk); n++; end
    chk({tag, "-rvalid_cycle"}, 64'(cyc), 64'(t_hs + 2 + RDL));
    chk({tag, "-rdata"}, rdata, exp_d);
    chk({tag, "-rresp"}, 64'(rresp), 64'(exp_resp));
    if (aligned) begin
      chk({tag, "-ren_count"}, 64'(ren_cnt), 64'(ren0 + 1));
      chk({tag, "-ren_cycle"}, 64'(ren_cyc), 64'(t_hs + 1));
      chk({tag, "-ren_addr"}, 64'(ren_addr), 64'(a[15:0]));
    end else begin
      chk({tag, "-no_ren"}, 64'(ren_cnt), 64'(ren0));
    end
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      chk({tag, "-rvalid_held"}, 64'(rvalid), 64'd1);
      chk({tag, "-rdata_held"}, rdata, exp_d);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    chk({tag, "-rvalid_drop"}, 64'(rvalid), 64'd0);
    chk({tag, "-arready_back"}, 64'(arready), 64'd1);
    chk({tag, "-single_ren"}, 64'(ren_cnt), 64'(ren0 + (aligned ? 1 : 0)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [7:0]  s;
    int          w0, r0;

    // Reset state and ready release.
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", 64'(any_out()), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("readies_after_reset", 64'({awready, wready, arready}), 64'h7);
    chk("no_valid_after_reset", 64'({bvalid, rvalid, reg_wen, reg_ren}), 64'd0);

    axi_write(32'h0000_0108, 64'h0000_0000_8000_0000, 8'hFF, 0, 0, 0, "t1_same_cycle");
    axi_write(32'h0000_0100, 64'h2000_0000_0003_0366, 8'hFF, 3, 0, 0, "t2_w_then_aw");
    axi_read (32'h0000_0100, 0, 0, "t3_read");
    axi_write(32'h0000_0111, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 0, 0, "t4_misaligned_wr");
    axi_write(32'h0000_0040, 64'hDEAD_BEEF_0000_0002, 8'h0F, 0, 1, 0, "t4_partial_strb");
    axi_read (32'h0000_0104, 0, 0, "t4_misaligned_rd");
    axi_read (32'h0000_0040, 0, 0, "t4_untouched_rd");

    w0 = wen_cnt; r0 = ren_cnt;
    fork
      axi_write(32'h0000_0208, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 0, 20, "t5_bp_write");
      axi_read (32'h0000_0300, 0, 20, "t5_bp_read");
    join
    chk("t5_one_wen", 64'(wen_cnt), 64'(w0 + 1));
    chk("t5_one_ren", 64'(ren_cnt), 64'(r0 + 1));

    // Reset in the handshake cycle of a write: the write must be abandoned.
    w0 = wen_cnt;
    @(negedge clk);
    awaddr = 32'h0000_0200; wdata = 64'hBAD0_BAD0_BAD0_BAD0; wstrb = 8'hFF;
    awvalid = 1; wvalid = 1; rst = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("t6w_outputs_zero", 64'(any_out()), 64'd0);
    @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    chk("t6w_no_wen", 64'(wen_cnt), 64'(w0));
    chk("t6w_no_bvalid", 64'(bvalid), 64'd0);

    // Reset while the read waits for data.
    r0 = ren_cnt;
    @(negedge clk);
    araddr = 32'h0000_0300; arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("t6r_outputs_zero", 64'(any_out()), 64'd0);
    chk("t6r_ren_before_rst", 64'(ren_cnt), 64'(r0 + 1));
    rst = 0;
    repeat (5) @(negedge clk);
    chk("t6r_no_rvalid", 64'(rvalid), 64'd0);
    chk("t6r_no_new_ren", 64'(ren_cnt), 64'(r0 + 1));
    axi_write(32'h0000_0200, 64'h0F0F_0F0F_A5A5_5A5A, 8'hFF, 0, 0, 1, "t6_fresh_write");
    axi_read (32'h0000_0200, 0, 0, "t6_fresh_read");

    // Randomized traffic against the register-map model; upper address bits alias.
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      a = {r[31:16], 6'd0, r[6:0], 3'd0};
      if (r[7] && r[8]) a[2:0] = r[11:9];
      s = 8'hFF;
      if (r[12] && r[13]) s = 8'($urandom);
      if (r[14]) axi_write(a, {$urandom, $urandom}, s, int'(r[17:16]), int'(r[19:18]), int'(r[21:20]), "rand_write");
      else       axi_read(a, int'(r[17:16]), int'(r[21:20]), "rand_read");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_axil_reg_bridge
`default_nettype wire
